// File: rtl/cb2tb_xfer_ctrl_if.sv
// Signal bundle between the EKF scheduler / BRAMs / TB input mapper and cb2tb_xfer_ctrl.
// slave: the view of the transfer controller itself; master: the view of its environment.
interface cb2tb_xfer_ctrl_if #(
  parameter int unsigned CB_AW          = 10,
  parameter int unsigned TB_AW          = 10,
  parameter int unsigned LEN_DW         = 10,
  parameter int unsigned SEQ_CNT_DW     = 10,
  parameter int unsigned TB_DINA_SEL_DW = 5
);
  // Scheduler request side
  logic                      start;
  logic [1:0]                dir;
  logic                      l_k_0;
  logic [CB_AW-1:0]          cb_base;
  logic [TB_AW-1:0]          tb_base;
  logic [LEN_DW-1:0]         len;
  logic                      stall;
  logic                      busy;
  logic                      done;
  // CB port A read side
  logic                      CB_ena;
  logic [CB_AW-1:0]          CB_addra;
  // TB input mapper controls
  logic [TB_DINA_SEL_DW-1:0] TB_dina_sel;
  logic                      l_k_0_out;
  logic [SEQ_CNT_DW-1:0]     seq_cnt_out;
  // TB port A write side
  logic                      TB_ena;
  logic                      TB_wea;
  logic [TB_AW-1:0]          TB_addra;

  modport slave (
    input  start, dir, l_k_0, cb_base, tb_base, len, stall,
    output busy, done, CB_ena, CB_addra, TB_dina_sel, l_k_0_out, seq_cnt_out,
           TB_ena, TB_wea, TB_addra
  );

  modport master (
    output start, dir, l_k_0, cb_base, tb_base, len, stall,
    input  busy, done, CB_ena, CB_addra, TB_dina_sel, l_k_0_out, seq_cnt_out,
           TB_ena, TB_wea, TB_addra
  );
endinterface

// File: rtl/cb2tb_xfer_ctrl.sv
// CB -> TB block transfer sequencer.
// Issues CB port A reads, drives the TB input mapper controls when the read data arrives,
// and writes TB port A one cycle later to match the mapper's output register.
// Optional macro TB_ADDR_WRAP_EN: TB addresses at or above TB_DEPTH fold back by TB_DEPTH,
// giving a circular TB region. Without it, TB addressing is plain modulo 2^TB_AW.
module cb2tb_xfer_ctrl #(
  parameter int unsigned CB_AW          = 10,
  parameter int unsigned TB_AW          = 10,
  parameter int unsigned LEN_DW         = 10,
  parameter int unsigned SEQ_CNT_DW     = 10,
  parameter int unsigned TB_DINA_SEL_DW = 5,
  parameter int unsigned CB_RD_LAT      = 1,
  parameter int unsigned TB_DEPTH       = 1024
) (
  input logic              clk,
  input logic              sys_rst_n,
  cb2tb_xfer_ctrl_if.slave bus
);

  if (LEN_DW > SEQ_CNT_DW || CB_RD_LAT < 1 || TB_DEPTH < 1 || TB_DINA_SEL_DW < 5) begin : g_cfg_err
    $error("cb2tb_xfer_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic                lk_q, lk_d;
  logic [CB_AW-1:0]    cb_base_q, cb_base_d;
  logic [TB_AW-1:0]    tb_base_q, tb_base_d;
  logic [LEN_DW-1:0]   len_q, len_d;
  logic [LEN_DW-1:0]   k_q, k_d;
  logic                issue;

  // Tag pipeline: element i is stage i+1; stage CB_RD_LAT feeds the mapper,
  // stage CB_RD_LAT+1 feeds the TB write port.
  logic [CB_RD_LAT:0]    vld_q, vld_d;
  logic [SEQ_CNT_DW-1:0] idx_q [CB_RD_LAT+1];
  logic [SEQ_CNT_DW-1:0] idx_d [CB_RD_LAT+1];

  logic             map_vld;
  logic             tb_vld;
  logic             rd_inflight;
  logic [TB_AW-1:0] tb_addr;

  assign map_vld     = vld_q[CB_RD_LAT-1];
  assign tb_vld      = vld_q[CB_RD_LAT];
  // Reads still travelling towards the mapper; the TB stage itself is excluded so DONE
  // lands on the cycle right after the final write.
  assign rd_inflight = |vld_q[CB_RD_LAT-1:0];

  // FSM next-state, parameter latching and read issue
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    lk_d      = lk_q;
    cb_base_d = cb_base_q;
    tb_base_d = tb_base_q;
    len_d     = len_q;
    k_d       = k_q;
    issue     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dir_d     = bus.dir;
          lk_d      = bus.l_k_0;
          cb_base_d = bus.cb_base;
          tb_base_d = bus.tb_base;
          len_d     = bus.len;
          k_d       = '0;
          state_d   = (bus.len == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (!bus.stall) begin
          issue = 1'b1;
          k_d   = k_q + LEN_DW'(1);
          if (k_q == len_q - LEN_DW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!rd_inflight) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Tag pipeline shift; a new tag carries the 1-based row index
  always_comb begin
    vld_d    = {vld_q[CB_RD_LAT-1:0], issue};
    idx_d[0] = issue ? (SEQ_CNT_DW'(k_q) + SEQ_CNT_DW'(1)) : '0;
    for (int unsigned i = 1; i <= CB_RD_LAT; i++) begin
      idx_d[i] = idx_q[i-1];
    end
  end

  // State, latched parameters and pipeline registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      dir_q     <= '0;
      lk_q      <= 1'b0;
      cb_base_q <= '0;
      tb_base_q <= '0;
      len_q     <= '0;
      k_q       <= '0;
      vld_q     <= '0;
      for (int unsigned i = 0; i <= CB_RD_LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      lk_q      <= lk_d;
      cb_base_q <= cb_base_d;
      tb_base_q <= tb_base_d;
      len_q     <= len_d;
      k_q       <= k_d;
      vld_q     <= vld_d;
      for (int unsigned i = 0; i <= CB_RD_LAT; i++) begin
        idx_q[i] <= idx_d[i];
      end
    end
  end

`ifdef TB_ADDR_WRAP_EN
  localparam int unsigned SumW = ((TB_AW > SEQ_CNT_DW) ? TB_AW : SEQ_CNT_DW) + 1;
  logic [SumW-1:0] tb_sum;

  // Circular TB region: a single fold by TB_DEPTH
  always_comb begin
    tb_sum = SumW'(tb_base_q) + SumW'(idx_q[CB_RD_LAT]) - SumW'(1);
    if (tb_sum >= SumW'(TB_DEPTH)) begin
      tb_sum = tb_sum - SumW'(TB_DEPTH);
    end
  end
  assign tb_addr = TB_AW'(tb_sum);
`else
  assign tb_addr = tb_base_q + TB_AW'(idx_q[CB_RD_LAT]) - TB_AW'(1);
`endif

  assign bus.CB_ena      = issue;
  assign bus.CB_addra    = issue ? (cb_base_q + CB_AW'(k_q)) : '0;
  assign bus.TB_dina_sel = map_vld ? TB_DINA_SEL_DW'({3'b100, dir_q}) : '0;
  assign bus.seq_cnt_out = map_vld ? idx_q[CB_RD_LAT-1] : '0;
  assign bus.l_k_0_out   = lk_q;
  assign bus.TB_ena      = tb_vld;
  assign bus.TB_wea      = tb_vld;
  assign bus.TB_addra    = tb_vld ? tb_addr : '0;
  assign bus.busy        = (state_q == StIssue) || (state_q == StDrain);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_cb2tb_xfer_ctrl.sv
// Scoreboard bench for cb2tb_xfer_ctrl: stimulus pushes expected CB reads, mapper beats,
// TB writes and done pulses (with their absolute cycle); a negedge monitor pops and compares.
module tb_cb2tb_xfer_ctrl;
  localparam int Lat     = 1;
  localparam int TbDepth = 16;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  cb2tb_xfer_ctrl_if #(
    .CB_AW(10), .TB_AW(10), .LEN_DW(10), .SEQ_CNT_DW(10), .TB_DINA_SEL_DW(5)
  ) bus ();

  cb2tb_xfer_ctrl #(
    .CB_AW(10), .TB_AW(10), .LEN_DW(10), .SEQ_CNT_DW(10), .TB_DINA_SEL_DW(5),
    .CB_RD_LAT(Lat), .TB_DEPTH(TbDepth)
  ) dut (
    .clk(clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  typedef struct {int cyc; int addr;} addr_t;
  typedef struct {int cyc; int sel; int lk; int seq;} map_t;

  addr_t cb_q[$];
  map_t  map_q[$];
  addr_t tb_q[$];
  int    done_q[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tb_exp_addr(input int a);
`ifdef TB_ADDR_WRAP_EN
    if (a >= TbDepth) a = a - TbDepth;
    return a % 1024;
`else
    return a % 1024;
`endif
  endfunction

  // Expected responses for a transfer started in cycle c0; returns the done cycle
  function automatic int plan(input int c0, input logic [1:0] d, input logic lk, input int cbb,
                              input int tbb, input int ln, input logic [15:0] smask);
    int k = 0;
    int n = 1;
    int last = c0;
    addr_t a;
    map_t m;
    while (k < ln) begin
      if (!(n < 16 && smask[n])) begin
        a.cyc = c0 + n;           a.addr = (cbb + k) % 1024;       cb_q.push_back(a);
        m.cyc = c0 + n + Lat;     m.sel = {3'b100, d};  m.lk = lk;  m.seq = k + 1;
        map_q.push_back(m);
        a.cyc = c0 + n + Lat + 1; a.addr = tb_exp_addr(tbb + k);   tb_q.push_back(a);
        last = c0 + n + Lat + 1;
        k++;
      end
      n++;
    end
    done_q.push_back(last + 1);
    return last + 1;
  endfunction

  // Monitor / scoreboard
  addr_t ce;
  map_t  me;
  int    de;
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (bus.CB_ena) begin
        if (cb_q.size() == 0) check("cb_unexpected", 1, 0);
        else begin
          ce = cb_q.pop_front();
          check("cb_cycle", cyc, ce.cyc);
          check("cb_addr", bus.CB_addra, ce.addr);
        end
      end
      if (bus.seq_cnt_out != 0) begin
        if (map_q.size() == 0) check("map_unexpected", 1, 0);
        else begin
          me = map_q.pop_front();
          check("map_cycle", cyc, me.cyc);
          check("map_sel", bus.TB_dina_sel, me.sel);
          check("map_lk", bus.l_k_0_out, me.lk);
          check("map_seq", bus.seq_cnt_out, me.seq);
        end
      end else begin
        check("sel_idle", bus.TB_dina_sel, 0);
      end
      if (bus.TB_wea || bus.TB_ena) begin
        if (tb_q.size() == 0) check("tb_unexpected", 1, 0);
        else begin
          ce = tb_q.pop_front();
          check("tb_cycle", cyc, ce.cyc);
          check("tb_ena_wea", {bus.TB_ena, bus.TB_wea}, 3);
          check("tb_addr", bus.TB_addra, ce.addr);
          check("tb_busy", bus.busy, 1);
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          de = done_q.pop_front();
          check("done_cycle", cyc, de);
          check("done_busy", bus.busy, 0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cb_ena"}, bus.CB_ena, 0);
    check({tag, "_cb_addr"}, bus.CB_addra, 0);
    check({tag, "_sel"}, bus.TB_dina_sel, 0);
    check({tag, "_lk_out"}, bus.l_k_0_out, 0);
    check({tag, "_seq"}, bus.seq_cnt_out, 0);
    check({tag, "_tb_ena"}, bus.TB_ena, 0);
    check({tag, "_tb_wea"}, bus.TB_wea, 0);
    check({tag, "_tb_addr"}, bus.TB_addra, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  task automatic run_xfer(input logic [1:0] d, input logic lk, input int cbb, input int tbb,
                          input int ln, input logic [15:0] smask, input int restart_at);
    int c0;
    int dc;
    @(posedge clk); #1;
    c0 = cyc;
    dc = plan(c0, d, lk, cbb, tbb, ln, smask);
    bus.start   = 1'b1;
    bus.dir     = d;
    bus.l_k_0   = lk;
    bus.cb_base = cbb[9:0];
    bus.tb_base = tbb[9:0];
    bus.len     = ln[9:0];
    bus.stall   = smask[0];
    for (int i = 1; i <= dc - c0 + 2; i++) begin
      @(posedge clk); #1;
      bus.stall = (i < 16) ? smask[i] : 1'b0;
      if (i == restart_at) begin
        bus.start   = 1'b1;
        bus.dir     = ~d;
        bus.l_k_0   = ~lk;
        bus.cb_base = 10'd777;
        bus.tb_base = 10'd333;
        bus.len     = 10'd9;
      end else begin
        bus.start = 1'b0;
      end
      if (i == 1) check("busy_after_start", bus.busy, (ln != 0) ? 1 : 0);
    end
    bus.stall = 1'b0;
  endtask

  initial begin
    int c0;
    int dc_before;
    bus.start = 1'b0; bus.dir = 2'b00; bus.l_k_0 = 1'b0; bus.cb_base = '0;
    bus.tb_base = '0; bus.len = '0; bus.stall = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 sys_rst_n = 1'b1;

    // Basic POS transfer
    run_xfer(2'b01, 1'b0, 5, 20, 3, 16'h0000, 0);
    // Same with a stall in cycle 2
    run_xfer(2'b01, 1'b0, 5, 20, 3, 16'h0004, 0);
    // Zero-length request
    run_xfer(2'b01, 1'b0, 9, 9, 0, 16'h0000, 0);
    // NEW transfer with an ignored start in cycle 2
    run_xfer(2'b11, 1'b1, 40, 60, 3, 16'h0000, 2);

    // Reset mid-ISSUE
    @(posedge clk); #1;
    c0 = cyc;
    void'(plan(c0, 2'b01, 1'b1, 100, 200, 4, 16'h0000));
    bus.start = 1'b1; bus.dir = 2'b01; bus.l_k_0 = 1'b1;
    bus.cb_base = 10'd100; bus.tb_base = 10'd200; bus.len = 10'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    check("pre_abort_cb_ena", bus.CB_ena, 1);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    cb_q.delete(); map_q.delete(); tb_q.delete(); done_q.delete();
    dc_before = done_cnt;
    repeat (2) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, dc_before);

    // Normal transfer after reset, CB address crossing 2^CB_AW
    run_xfer(2'b10, 1'b0, 1022, 3, 4, 16'h0000, 0);
    // TB region boundary
    run_xfer(2'b00, 1'b0, 50, 14, 4, 16'h0000, 0);

    repeat (3) @(posedge clk);
    #1;
    check("cb_left", cb_q.size(), 0);
    check("map_left", map_q.size(), 0);
    check("tb_left", tb_q.size(), 0);
    check("done_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cb2tb_xfer_ctrl.md
Name: cb2tb_xfer_ctrl

Overview:
- Sequencer that moves a block of rows from the cache buffer (CB) port A into the temp buffer (TB) port A.
- Issues the CB reads and drives the select, sequence and l_k_0 inputs of the TB input mapper on the cycle that mapper samples the CB read data.
- Generates the TB write enable and address, aligned to the mapper's registered output.
- Sits between the top-level EKF scheduler (start/done handshake) and the CB BRAM, TB input mapper and TB BRAM.

Parameters:
- CB_AW, 10, CB address width.
- TB_AW, 10, TB address width.
- LEN_DW, 10, row-count width; must be ≤ SEQ_CNT_DW.
- SEQ_CNT_DW, 10, width of seq_cnt_out.
- TB_DINA_SEL_DW, 5, width of the mapper select.
- CB_RD_LAT, 1, CB BRAM read latency in cycles (≥1).
- TB_DEPTH, 1024, TB row count; used only with TB_ADDR_WRAP_EN.

Ports:
- clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- dir  in  2  mapping direction: 00 clear, 01 POS, 10 NEG, 11 NEW
- l_k_0  in  1  landmark half-select for NEW; latched at start
- cb_base  in  CB_AW  first CB row
- tb_base  in  TB_AW  first TB row
- len  in  LEN_DW  number of rows
- stall  in  1  suppresses new CB reads while high
- CB_ena  out  1  CB port A read enable
- CB_addra  out  CB_AW  CB read address
- TB_dina_sel  out  TB_DINA_SEL_DW  mapper select
- l_k_0_out  out  1  latched l_k_0 to the mapper
- seq_cnt_out  out  SEQ_CNT_DW  1-based row index at the mapper input; 0 when idle
- TB_ena  out  1  TB port A enable
- TB_wea  out  1  TB write enable
- TB_addra  out  TB_AW  TB write address
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and all pipeline valids are cleared.
  - Reset asserted mid-transfer aborts the transfer immediately. No done pulse is produced.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1:
  - Latch dir, l_k_0, cb_base, tb_base and len. Clear the issue counter.
  - Go to ISSUE if len≠0; otherwise go to DONE.
- start outside IDLE is ignored. The latched parameters do not change.
- ISSUE, each cycle with stall=0:
  - CB_ena=1, CB_addra = cb_base + k, where k counts 0..len-1.
  - A tag {valid, k+1} enters the pipeline.
  - After issuing k = len-1, go to DRAIN.
- ISSUE with stall=1: CB_ena=0, no tag is issued, and the counter holds. Tags already issued keep advancing.
- Pipeline: tag stage CB_RD_LAT drives the mapper inputs.
  - valid: TB_dina_sel = {3'b100, dir}, seq_cnt_out = tag index.
  - invalid: TB_dina_sel = 0, seq_cnt_out = 0.
  - l_k_0_out holds the latched value for the whole transfer.
- The mapper registers its output, so the TB write uses stage CB_RD_LAT+1:
  - TB_ena = TB_wea = valid.
  - TB_addra = tb_base + index - 1.
  - Total latency from CB_ena to the matching TB_wea is CB_RD_LAT+1 cycles.
- DRAIN: go to DONE in the cycle after the last valid TB_wea.
- DONE: done=1 for one cycle, then IDLE. busy=0 in the DONE cycle.
- TB address arithmetic is modulo 2^TB_AW without the optional feature. CB address is always modulo 2^CB_AW.
- dir=00 is a legal clear transfer: the mapper emits zeros, so len TB rows are zeroed.

Optional Feature:
- Macro: TB_ADDR_WRAP_EN.
- Defined: when tb_base + index - 1 ≥ TB_DEPTH, the TB address has TB_DEPTH subtracted, giving a circular TB region.
- Not defined: plain modulo-2^TB_AW addition, with no comparator in the path.

Test Plan:
- Reset, then start with dir=01, cb_base=5, tb_base=20, len=3, CB_RD_LAT=1:
  - CB_ena high on cycles 1-3 with addresses 5, 6, 7.
  - TB_dina_sel=5'b10001 and seq_cnt_out 1/2/3 on cycles 2-4.
  - TB_wea on cycles 3-5 with addresses 20, 21, 22.
  - done on cycle 6.
- Same transfer with stall=1 on cycle 2 only: CB addresses 5, _, 6, 7. The TB_wea gap appears exactly 2 cycles later. Addresses stay contiguous and done slips by one cycle.
- Start with len=0: no CB_ena and no TB_wea; done pulses on the cycle after start.
- Start pulse on cycle 2 of a running transfer (dir=11, l_k_0=1): ignored. l_k_0_out stays 1 and TB_dina_sel stays 5'b10011 for all rows.
- Drop sys_rst_n mid-ISSUE: all outputs 0 asynchronously, no done pulse. A new start after release runs normally.
- With TB_ADDR_WRAP_EN, TB_DEPTH=16, tb_base=14, len=4: TB addresses 14, 15, 0, 1. Without the macro: 14, 15, 16, 17.
